// File: rtl/inst_prefetch_queue_pkg.sv
// Shared fetch-side widths and types for the instruction prefetch queue.
package inst_prefetch_queue_pkg;

    localparam int unsigned PF_INST_W = 68;
    localparam int unsigned PF_PC_W   = 32;

    typedef logic [PF_INST_W-1:0] inst_word_t;
    typedef logic [PF_PC_W-1:0]   fetch_pc_t;

    typedef struct packed {
        fetch_pc_t  pc;
        inst_word_t inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Redirect, instruction-memory and instruction-register signals of the prefetch queue.
// inst_pc exists only when PF_PC_TAG_EN is defined.
interface inst_prefetch_queue_if
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned INST_W = PF_INST_W,
    parameter int unsigned PC_W   = PF_PC_W
);

    logic              flush;
    logic [PC_W-1:0]   flush_pc;
    logic              mem_req;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_valid;
    logic [INST_W-1:0] mem_inst;
    logic              inst_valid;
    logic [INST_W-1:0] inst_out;
    logic              inst_ready;
    logic              err;
`ifdef PF_PC_TAG_EN
    logic [PC_W-1:0]   inst_pc;
`endif

    modport master (
        input  flush, flush_pc, mem_valid, mem_inst, inst_ready,
`ifdef PF_PC_TAG_EN
        output inst_pc,
`endif
        output mem_req, mem_addr, inst_valid, inst_out, err
    );

    modport slave (
        output flush, flush_pc, mem_valid, mem_inst, inst_ready,
`ifdef PF_PC_TAG_EN
        input  inst_pc,
`endif
        input  mem_req, mem_addr, inst_valid, inst_out, err
    );

endinterface

// File: rtl/inst_prefetch_queue_pf_fifo_core.sv
// FIFO storage with clear and a registered first-word-fall-through head that
// keeps its last value while the FIFO is empty.
module pf_fifo_core
    import inst_prefetch_queue_pkg::*;
#(
    parameter  int unsigned W     = PF_INST_W,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  head_q, head_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        head_d = head_q;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_pop)  rd_d = rd_q + 1'b1;
            if (do_push) wr_d = wr_q + 1'b1;
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
            // The incoming word becomes head when it lands in the slot rd_d points at.
            if (cnt_d != '0)
                head_d = (do_push && (wr_q == rd_d)) ? wdata_i : mem_q[rd_d];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i)
            mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = head_q;
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/inst_prefetch_queue.sv
// Fetch PC, credit-limited in-order memory requests, redirect drop accounting and
// the instruction FIFO feeding the IR. PF_PC_TAG_EN adds a per-entry fetch-PC tag.
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned     INST_W   = PF_INST_W,
    parameter int unsigned     PC_W     = PF_PC_W,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     PC_STEP  = 1,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_prefetch_queue_if.master pf
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              err_q, err_d;
    logic [CW-1:0]     q_count;
    logic [CW:0]       credit_used;
    logic              q_empty, q_full;
    logic              issue, ret_drop, ret_accept, ret_stray, push, pop;
    logic [INST_W-1:0] word_head;
    logic              unused_q_full;

    assign credit_used = {1'b0, q_count} + {1'b0, outst_q};
    assign issue       = !pf.flush && (credit_used < (CW+1)'(DEPTH));

    assign ret_drop    = pf.mem_valid && (drop_q != '0);
    assign ret_accept  = pf.mem_valid && (drop_q == '0) && (outst_q != '0);
    assign ret_stray   = pf.mem_valid && (drop_q == '0) && (outst_q == '0);
    assign push        = ret_accept && !pf.flush;
    assign pop         = !q_empty && pf.inst_ready;

    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        err_d   = err_q | ret_stray;
        if (pf.flush) begin
            pc_d    = pf.flush_pc;
            outst_d = '0;
            // Everything still in flight becomes drop credit, minus a word landing now.
            drop_d  = drop_q + outst_q - CW'(ret_drop || ret_accept);
        end else begin
            if (issue) pc_d = pc_q + PC_W'(PC_STEP);
            outst_d = outst_q + CW'(issue) - CW'(ret_accept);
            drop_d  = drop_q - CW'(ret_drop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    pf_fifo_core #(
        .W     (INST_W),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (pf.flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (pf.mem_inst),
        .rdata_o (word_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign unused_q_full = q_full;
    assign pf.mem_req    = issue && !rst;
    assign pf.mem_addr   = pc_q;
    assign pf.inst_valid = !q_empty;
    assign pf.err        = err_q;

`ifdef PF_PC_TAG_EN
    logic [PC_W-1:0] ret_pc, tag_head;
    logic [CW-1:0]   unused_tag_count;
    logic            unused_tag_full, unused_tag_empty;
    fetch_entry_t    head_ent;

    // Returns after the last redirect are contiguous, so the oldest outstanding
    // request sits outstanding*PC_STEP behind the fetch PC.
    assign ret_pc = pc_q - PC_W'(outst_q) * PC_W'(PC_STEP);

    pf_fifo_core #(
        .W     (PC_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (pf.flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (ret_pc),
        .rdata_o (tag_head),
        .count_o (unused_tag_count),
        .full_o  (unused_tag_full),
        .empty_o (unused_tag_empty)
    );

    assign head_ent    = '{pc: tag_head, inst: word_head};
    assign pf.inst_pc  = head_ent.pc;
    assign pf.inst_out = head_ent.inst;
`else
    assign pf.inst_out = word_head;
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomised bench for inst_prefetch_queue against a queue-based fetch model
// with an in-order variable-latency memory.
module tb_inst_prefetch_queue;
    import inst_prefetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_prefetch_queue_if #(.INST_W(PF_INST_W), .PC_W(PF_PC_W)) pf0 ();
    inst_prefetch_queue_if #(.INST_W(PF_INST_W), .PC_W(PF_PC_W)) pf1 ();

    inst_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .pf  (pf0)
    );

    inst_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'hFFFF_FFFF)
    ) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .pf  (pf1)
    );

    typedef struct {
        bit          live;
        logic [31:0] addr;
    } infl_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } ret_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_due;
    int          wrap_n;
    logic [31:0] wrap_pc;
    infl_t       infl[$];
    logic [67:0] mq[$];
    ret_t        mp[$];
    logic [31:0] m_pc;
    logic [67:0] m_last;
    bit          m_err;

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [67:0] word_of(input logic [31:0] a);
        return {a[3:0] ^ 4'h5, a * 32'h9E37_79B1, ~a};
    endfunction

    task automatic model_reset();
        infl.delete();
        mq.delete();
        mp.delete();
        m_pc     = 32'h0;
        m_last   = '0;
        m_err    = 1'b0;
        last_due = 0;
        wrap_n   = 0;
        wrap_pc  = 32'hFFFF_FFFF;
    endtask

    task automatic drive_idle();
        pf0.flush = 1'b0; pf0.flush_pc = '0; pf0.mem_valid = 1'b0; pf0.mem_inst = '0; pf0.inst_ready = 1'b0;
        pf1.flush = 1'b0; pf1.flush_pc = '0; pf1.mem_valid = 1'b0; pf1.mem_inst = '0; pf1.inst_ready = 1'b0;
    endtask

    task automatic cycle(input bit do_flush, input logic [31:0] fpc, input bit ready,
                         input int lat, input bit stray);
        bit          req, mv;
        logic [67:0] mw;
        logic [95:0] r96;
        int          live, due;
        @(negedge clk);
        cyc++;
        mv = 1'b0;
        mw = '0;
        if (mp.size() > 0 && mp[0].due <= cyc) begin
            mv = 1'b1;
            mw = word_of(mp[0].addr);
            mp.delete(0);
        end else if (stray && mp.size() == 0 && infl.size() == 0) begin
            r96 = {$urandom(), $urandom(), $urandom()};
            mv  = 1'b1;
            mw  = r96[67:0];
        end
        pf0.flush      = do_flush;
        pf0.flush_pc   = fpc;
        pf0.mem_valid  = mv;
        pf0.mem_inst   = mw;
        pf0.inst_ready = ready;
        live = 0;
        foreach (infl[i]) if (infl[i].live) live++;
        req = !do_flush && (mq.size() + live < DEPTH);
        #1;
        chk("mem_req",    68'(pf0.mem_req),    68'(req));
        chk("mem_addr",   68'(pf0.mem_addr),   68'(m_pc));
        chk("inst_valid", 68'(pf0.inst_valid), 68'(mq.size() > 0));
        chk("inst_out",   pf0.inst_out,        m_last);
        chk("err",        68'(pf0.err),        68'(m_err));
        if (wrap_n < 3) begin
            chk("wrap_req",  68'(pf1.mem_req),  68'(1));
            chk("wrap_addr", 68'(pf1.mem_addr), 68'(wrap_pc));
            wrap_pc = wrap_pc + 32'd1;
            wrap_n++;
        end
        // Reference behaviour for the coming rising edge.
        if (mq.size() > 0 && ready) mq.delete(0);
        if (mv) begin
            if (infl.size() == 0) m_err = 1'b1;
            else begin
                if (infl[0].live && !do_flush) mq.push_back(word_of(infl[0].addr));
                infl.delete(0);
            end
        end
        if (do_flush) begin
            mq.delete();
            foreach (infl[i]) infl[i].live = 1'b0;
            m_pc = fpc;
        end else if (req) begin
            infl.push_back('{1'b1, m_pc});
            due = (last_due + 1 > cyc + lat) ? last_due + 1 : cyc + lat;
            mp.push_back('{due, m_pc});
            last_due = due;
            m_pc = m_pc + 32'd1;
        end
        if (mq.size() > 0) m_last = mq[0];
    endtask

    task automatic random_cycles(input int n);
        bit          fl;
        logic [31:0] fpc;
        for (int i = 0; i < n; i++) begin
            fl = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       fpc = 32'h0000_0100;
                1:       fpc = 32'hFFFF_FFFE;
                default: fpc = $urandom();
            endcase
            cycle(fl, fpc, $urandom_range(0, 3) != 0, int'($urandom_range(1, 3)), 1'b0);
        end
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_req",    68'(pf0.mem_req),    68'(0));
        chk("reset_inst_valid", 68'(pf0.inst_valid), 68'(0));
        chk("reset_inst_out",   pf0.inst_out,        68'(0));
        chk("reset_err",        68'(pf0.err),        68'(0));
        #1;
        rst = 1'b0;

        // Single-cycle memory, consumer always ready.
        repeat (40) cycle(1'b0, 32'h0, 1'b1, 1, 1'b0);
        // Consumer stalled, then released.
        repeat (12) cycle(1'b0, 32'h0, 1'b0, 1, 1'b0);
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1, 1'b0);
        // Redirect to 0x100 with latency-3 memory and words in flight.
        repeat (5) cycle(1'b0, 32'h0, 1'b0, 3, 1'b0);
        cycle(1'b1, 32'h0000_0100, 1'b1, 3, 1'b0);
        repeat (15) cycle(1'b0, 32'h0, 1'b1, 3, 1'b0);
        // Back-to-back redirects.
        cycle(1'b1, 32'h0000_0200, 1'b0, 2, 1'b0);
        cycle(1'b1, 32'h0000_0300, 1'b1, 2, 1'b0);
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 2, 1'b0);

        random_cycles(1500);

        // Stray return once nothing is in flight; err must stick.
        repeat (10) cycle(1'b0, 32'h0, 1'b0, 1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1, 1'b1);
        repeat (8) cycle(1'b0, 32'h0, 1'b1, 1, 1'b0);
        random_cycles(100);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_mem_req",    68'(pf0.mem_req),    68'(0));
        chk("async_rst_inst_valid", 68'(pf0.inst_valid), 68'(0));
        chk("async_rst_inst_out",   pf0.inst_out,        68'(0));
        chk("async_rst_err",        68'(pf0.err),        68'(0));
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        random_cycles(300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
Fetch-side prefetch engine directly upstream of the current instruction register. It owns the fetch PC and issues in-order read requests to instruction memory. It buffers returned 68-bit instruction words in a small FIFO and presents them to the instruction register with a valid/ready handshake. A redirect (flush) from branch resolution discards queued and in-flight words and restarts fetch at a new PC.

Parameters:
INST_W, 68, instruction word width
PC_W, 32, fetch address width
DEPTH, 4, queue entries; power of two, 2..16
PC_STEP, 1, address increment per fetched word
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  redirect fetch; sampled each rising edge
flush_pc  in  PC_W  new fetch address, valid with flush
mem_req  out  1  read request this cycle; memory always accepts
mem_addr  out  PC_W  request address (current PC)
mem_valid  in  1  one returned word, strictly in request order
mem_inst  in  INST_W  returned word
inst_valid  out  1  head entry valid (drives IR write enable)
inst_out  out  INST_W  head entry, first-word-fall-through
inst_ready  in  1  consumer accepts head this cycle
err  out  1  sticky: mem_valid seen with nothing outstanding

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. On reset: pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0; err=0. Outputs during and after reset: mem_req=0, inst_valid=0, inst_out=0.
- State: pc; FIFO of DEPTH entries (rd_ptr, wr_ptr, count); outstanding counter; drop_cnt counter. Counters are $clog2(DEPTH)+1 bits wide.
- Issue: mem_req = !flush && (count + outstanding < DEPTH). mem_req is combinational from registered state plus flush. mem_addr = pc. On an issue edge: pc <= pc + PC_STEP, with modulo 2^PC_W wrap (0xFFFFFFFF -> 0x0). outstanding increments.
- Credit rule: the queue can never overflow; every in-flight word has a reserved slot.
- Return, drop_cnt>0: the word is discarded and drop_cnt decrements.
- Return, drop_cnt==0 and outstanding>0: the word is written at wr_ptr. inst_valid rises on the next edge (latency 1 cycle from mem_valid to inst_valid).
- Return, outstanding+drop_cnt==0: the word is ignored and err <= 1.
- Outstanding bookkeeping: outstanding decrements on every accepted, non-dropped return. Issue and return in the same cycle leave it unchanged.
- Pop: occurs when inst_valid && inst_ready. rd_ptr advances and count decrements.
- Simultaneous push and pop: count is unchanged. This is legal even when full and even when count==1 (no bubble).
- Empty queue: inst_valid=0 and inst_out holds its last value. There is no bypass from mem_inst to inst_out.
- Throughput: 1 word/cycle sustained with single-cycle memory and inst_ready held high.
- Flush edge:
  - pc <= flush_pc; queue cleared (count=0, pointers to 0); outstanding <= 0.
  - drop_cnt <= drop_cnt + outstanding - (1 if a return arrives this cycle).
  - A pop in the flush cycle has no effect beyond the clear.
  - mem_req is 0 in the flush cycle. Fetch at flush_pc issues on the next cycle.
- Back-to-back flushes: the last flush_pc wins, and drop_cnt accumulates correctly.
- Pointer behaviour: pointers wrap modulo DEPTH.

Optional Feature:
PF_PC_TAG_EN
- Defined: each entry also stores its fetch address (PC_W bits) in a parallel tag FIFO. The tag is output on added port inst_pc (out, PC_W) and is aligned with inst_out. inst_pc resets to 0.
- Undefined: the port and tag storage are absent; behaviour is otherwise identical.

Decomposition:
- Shared fetch package:
  - INST_W=68 and PC_W=32 constants.
  - Instruction word typedef.
  - Fetch-entry struct {pc, inst} used when PF_PC_TAG_EN is defined.
- One sub-module, pf_fifo_core:
  - Parameterised storage, pointers and count.
  - Provides push/pop/clear and full/empty.
  - Instantiated once for words and once more for tags under PF_PC_TAG_EN.
- Credit, pc and drop logic stay in the top.

Test Plan:
1. Reset with rst asserted mid-run (async, between edges) -> mem_req, inst_valid, err drop to 0 immediately; after release the first mem_addr = 0x0.
2. 1-cycle memory, inst_ready=1 -> mem_addr 0,1,2,3,...; inst_out appears one cycle after each mem_valid at one word per cycle, in order.
3. inst_ready=0 with DEPTH=4 -> exactly 4 requests (addrs 0..3), then mem_req=0. Raising inst_ready pops one word per cycle and the request at addr 4 reissues.
4. Memory latency 3, flush with flush_pc=0x100 while 2 words are outstanding and 1 is queued -> queue empties; the next 2 returns are dropped; the first delivered word is the one from addr 0x100.
5. RESET_PC=0xFFFFFFFF -> mem_addr sequence 0xFFFFFFFF, 0x0, 0x1.
6. mem_valid pulsed with no request outstanding -> err=1 and stays set until rst; queue is unchanged.
